// File: rtl/vrom_pkg.sv
// Shared types and sizing helpers for the VRom stream reader.
package vrom_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    function automatic int data_len(input int width, input int size);
        return width * size;
    endfunction

    // The rom_addr register is a pipeline stage of its own, so the buffer must
    // cover ROM_LATENCY+1 reads in flight plus the beat being presented.
    function automatic int fifo_depth(input int rom_latency);
        return rom_latency + 2;
    endfunction

endpackage

// File: rtl/vrom_rd_fifo.sv
// Synchronous FIFO with registered head; count drives the reader's credit check.
module vrom_rd_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 9,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic                        full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/vrom_stream_reader.sv
// Burst sequencer in front of VRom: issues addresses under credit control, streams data out.
// Optional VROM_READER_CHECKSUM_EN adds a per-burst XOR checksum (csum/csum_valid).
module vrom_stream_reader
    import vrom_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_SIZE   = 1,
    parameter int ROM_LATENCY = 1,
    localparam int DATA_LEN   = data_len(DATA_WIDTH, DATA_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH:0]   req_len,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_LEN-1:0]   rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_data,
    output logic                  out_last,
`ifdef VROM_READER_CHECKSUM_EN
    output logic [DATA_LEN-1:0]   csum,
    output logic                  csum_valid,
`endif
    output logic                  busy
);
    localparam int DEPTH  = fifo_depth(ROM_LATENCY);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CR_W   = CNT_W + 2;
    localparam int STAGES = ROM_LATENCY;
    localparam logic [ADDR_WIDTH:0]   ONE_L = 1;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

    state_t              state;
    logic [ADDR_WIDTH:0] remaining;
    logic [STAGES:0]     vld_pipe, last_pipe;
    logic [CNT_W-1:0]    occ;
    logic [CR_W-1:0]     inflight;
    logic                fifo_empty, pop, accept, issue_ok;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign accept    = req_valid & req_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= STAGES; i++) inflight = inflight + CR_W'(vld_pipe[i]);
    end

    // A beat leaving this cycle frees its slot for the read issued now.
    assign issue_ok = (CR_W'(occ) + inflight) < (CR_W'(DEPTH) + CR_W'(pop));

    // vld_pipe[0] tags the address held in rom_addr; vld_pipe[STAGES] lines up with rom_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rom_addr  <= '0;
            remaining <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
            last_pipe[STAGES:1] <= last_pipe[STAGES-1:0];
            vld_pipe[0]         <= 1'b0;
            last_pipe[0]        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && req_len != '0) begin
                        rom_addr     <= req_addr;
                        remaining    <= req_len - ONE_L;
                        vld_pipe[0]  <= 1'b1;
                        last_pipe[0] <= (req_len == ONE_L);
                        state        <= (req_len == ONE_L) ? ST_DRAIN : ST_ISSUE;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ok) begin
                        rom_addr     <= rom_addr + ONE_A;
                        remaining    <= remaining - ONE_L;
                        vld_pipe[0]  <= 1'b1;
                        last_pipe[0] <= (remaining == ONE_L);
                        if (remaining == ONE_L) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    vrom_rd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_LEN + 1)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (vld_pipe[STAGES]),
        .push_data ({last_pipe[STAGES], rom_data}),
        .pop       (pop),
        .head      ({out_last, out_data}),
        .empty     (fifo_empty),
        .count     (occ)
    );

`ifdef VROM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum       <= '0;
            csum_valid <= 1'b0;
        end else begin
            csum_valid <= pop & out_last;
            if (accept)   csum <= '0;
            else if (pop) csum <= csum ^ out_data;
        end
    end
`endif

endmodule
